shift_add_mult: RTL

Sequential shift-and-add unsigned multiplier for the 4x4 multiplier datapath. It sits directly downstream of the 1-bit full-adder cells and consumes their sum and carry outputs through a WIDTH-bit ripple adder. Each iteration conditionally adds the multiplicand into an accumulator and then shifts. It accepts operands on a start pulse and returns a 2*WIDTH-bit product with a one-cycle done pulse.

---
 rtl/mult_pkg.sv | 13 +
 rtl/adder_1bit.sv | 13 +
 rtl/adder_nbit.sv | 29 ++
 rtl/shift_add_mult.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and default operand width for the shift-add multiplier
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_1bit.sv
// rtl/adder_1bit.sv - single-bit full adder cell
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_nbit.sv
// rtl/adder_nbit.sv - WIDTH-bit ripple-carry adder built from adder_1bit cells, carry-in tied to 0
module adder_nbit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    adder_1bit u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-and-add unsigned multiplier; MULT_ZERO_SKIP_EN folds zero-bit iterations into one cycle
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m_q, m_nxt;
  logic [WIDTH-1:0]   acc_q, acc_nxt;
  logic [WIDTH-1:0]   q_q, q_nxt;
  logic               c_q, c_nxt;
  logic [CW-1:0]      cnt_q, cnt_nxt;
  logic [2*WIDTH-1:0] product_q, product_nxt;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .a   (acc_q),
    .b   (m_q),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      m_q       <= m_nxt;
      acc_q     <= acc_nxt;
      q_q       <= q_nxt;
      c_q       <= c_nxt;
      cnt_q     <= cnt_nxt;
      product_q <= product_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    m_nxt       = m_q;
    acc_nxt     = acc_q;
    q_nxt       = q_q;
    c_nxt       = c_q;
    cnt_nxt     = cnt_q;
    product_nxt = product_q;
    busy        = (state != IDLE);
    done        = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          m_nxt     = a;
          q_nxt     = b;
          acc_nxt   = '0;
          c_nxt     = 1'b0;
          cnt_nxt   = CW'(WIDTH);
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (q_q[0]) begin
          {c_nxt, acc_nxt} = {add_cout, add_sum};
          state_nxt        = SHIFT;
        end else begin
`ifdef MULT_ZERO_SKIP_EN
          // carry is cleared by the skipped add, so the shift brings in zero
          {c_nxt, acc_nxt, q_nxt} = {1'b0, 1'b0, acc_q, q_q[WIDTH-1:1]};
          cnt_nxt                 = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            product_nxt = {acc_nxt, q_nxt};
            state_nxt   = DONE;
          end else begin
            state_nxt = ADD;
          end
`else
          c_nxt     = 1'b0;
          state_nxt = SHIFT;
`endif
        end
      end
      SHIFT: begin
        {c_nxt, acc_nxt, q_nxt} = {1'b0, c_q, acc_q, q_q[WIDTH-1:1]};
        cnt_nxt                 = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_nxt = {acc_nxt, q_nxt};
          state_nxt   = DONE;
        end else begin
          state_nxt = ADD;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign product = product_q;

endmodule
